// File: rtl/fetch_buffer.sv
// Circular instruction queue between fetch/predecode and decode.
// Accepts up to ENQ_WIDTH entries per cycle; presents the oldest DECODE_WIDTH to decode.
package fetch_buffer_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
endpackage

module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned ENQ_WIDTH    = 4,
  parameter int unsigned DECODE_WIDTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_squash_vld,
  input  logic [ENQ_WIDTH-1:0]                 i_enq_vld,
  input  fetch_entry_t [ENQ_WIDTH-1:0]         i_enq_inst,
  output logic                                 o_enq_ready,
  output logic [DECODE_WIDTH-1:0]              o_inst_vld,
  output fetch_entry_t [DECODE_WIDTH-1:0]      o_inst,
  input  logic [DECODE_WIDTH-1:0]              i_can_deq,
  output logic [$clog2(DEPTH):0]               o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     storage [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] enq_n;
  logic [CNT_W-1:0] deq_n;
  logic             enq_fire;

  // Ready looks only at registered occupancy, so dequeue never feeds back into it.
  assign o_enq_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(ENQ_WIDTH);
  assign enq_fire    = o_enq_ready && !i_squash_vld;
  assign o_count     = count;

  always_comb begin
    enq_n = '0;
    for (int k = 0; k < ENQ_WIDTH; k++) begin
      if (enq_fire && i_enq_vld[k]) enq_n = enq_n + CNT_W'(1);
    end
  end

  always_comb begin
    o_inst_vld = '0;
    o_inst     = '0;
    for (int k = 0; k < DECODE_WIDTH; k++) begin
      o_inst_vld[k] = (count > CNT_W'(k)) && !i_squash_vld;
      o_inst[k]     = storage[head + PTR_W'(k)];
    end
  end

  always_comb begin
    deq_n = '0;
    for (int k = 0; k < DECODE_WIDTH; k++) begin
      if (i_can_deq[k] && o_inst_vld[k]) deq_n = deq_n + CNT_W'(1);
    end
  end

  // Storage has no reset; only slots behind tail are ever written.
  always_ff @(posedge clk) begin
    for (int k = 0; k < ENQ_WIDTH; k++) begin
      if (CNT_W'(k) < enq_n) storage[tail + PTR_W'(k)] <= i_enq_inst[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_squash_vld) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(deq_n);
      tail  <= tail + PTR_W'(enq_n);
      count <= count + enq_n - deq_n;
    end
  end

  // Protocol checks on the fetch and decode handshakes.
  always @(posedge clk) begin
    if (!rst) begin
      assert (((i_enq_vld + ENQ_WIDTH'(1)) & i_enq_vld) == '0)
        else $error("i_enq_vld not a contiguous prefix: %b", i_enq_vld);
      assert (i_squash_vld || i_can_deq == '0 || i_can_deq == o_inst_vld)
        else $error("i_can_deq %b does not match o_inst_vld %b", i_can_deq, o_inst_vld);
      assert (count <= CNT_W'(DEPTH))
        else $error("occupancy %0d exceeds depth", count);
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed and randomized bench for fetch_buffer against a queue-based reference model.
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned EW    = 4;
  localparam int unsigned DW    = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    i_squash_vld;
  logic [EW-1:0]           i_enq_vld;
  fetch_entry_t [EW-1:0]   i_enq_inst;
  logic                    o_enq_ready;
  logic [DW-1:0]           o_inst_vld;
  fetch_entry_t [DW-1:0]   o_inst;
  logic [DW-1:0]           i_can_deq;
  logic [4:0]              o_count;

  int vectors     = 0;
  int miscompares = 0;
  fetch_entry_t q[$];

  fetch_buffer #(.DEPTH(DEPTH), .ENQ_WIDTH(EW), .DECODE_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_squash_vld (i_squash_vld),
    .i_enq_vld    (i_enq_vld),
    .i_enq_inst   (i_enq_inst),
    .o_enq_ready  (o_enq_ready),
    .o_inst_vld   (o_inst_vld),
    .o_inst       (o_inst),
    .i_can_deq    (i_can_deq),
    .o_count      (o_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // One clock: drive, check against model, clock, advance model.
  task automatic step(input logic r, input logic sq, input logic [EW-1:0] ev, input logic de);
    logic [DW-1:0] avail;
    logic          rdy;
    int            n;
    int            dq;
    n     = q.size();
    avail = '0;
    for (int k = 0; k < DW; k++) if (k < n) avail[k] = 1'b1;
    rdy = (DEPTH - n) >= EW;
    rst          = r;
    i_squash_vld = sq;
    i_enq_vld    = ev;
    i_can_deq    = de ? avail : '0;
    for (int k = 0; k < EW; k++) i_enq_inst[k] = '{pc: $urandom, inst: $urandom};
    #3;
    chk("count", 64'(o_count), 64'(n));
    chk("ready", 64'(o_enq_ready), 64'(rdy));
    chk("vld", 64'(o_inst_vld), sq ? 64'(0) : 64'(avail));
    for (int k = 0; k < DW; k++) if (k < n) chk($sformatf("inst%0d", k), 64'(o_inst[k]), 64'(q[k]));
    @(posedge clk);
    if (r || sq) begin
      q.delete();
    end else begin
      dq = de ? ((n < DW) ? n : DW) : 0;
      repeat (dq) void'(q.pop_front());
      if (rdy) for (int k = 0; k < EW; k++) if (ev[k]) q.push_back(i_enq_inst[k]);
    end
    #1;
  endtask

  function automatic logic [EW-1:0] rand_prefix();
    int len;
    len = $urandom_range(0, EW);
    return EW'((1 << len) - 1);
  endfunction

  initial begin
    rst = 1'b1; i_squash_vld = 1'b0; i_enq_vld = '0; i_can_deq = '0; i_enq_inst = '0;
    @(posedge clk); #1;
    step(1, 0, 4'b0000, 0);
    // Full-width enqueue, then drain
    step(0, 0, 4'b1111, 0);
    step(0, 0, 4'b0000, 1);
    step(0, 0, 4'b0000, 0);
    // Partial enqueue into empty buffer
    step(0, 0, 4'b0011, 0);
    step(0, 0, 4'b0000, 1);
    step(0, 0, 4'b0000, 1);
    // Fill with decode stalled; attempts past capacity are dropped
    for (int i = 0; i < 6; i++) step(0, 0, 4'b1111, 0);
    // Wrap: steady enqueue and dequeue across index 15 -> 0
    for (int i = 0; i < 10; i++) step(0, 0, 4'b1111, 1);
    // Squash at occupancy 9 with simultaneous enq and deq
    step(1, 0, 4'b0000, 0);
    step(0, 0, 4'b1111, 0);
    step(0, 0, 4'b1111, 0);
    step(0, 0, 4'b0001, 0);
    step(0, 1, 4'b1111, 1);
    step(0, 0, 4'b0000, 0);
    // Reset mid-stream at occupancy 7, then normal enqueue
    step(0, 0, 4'b1111, 0);
    step(0, 0, 4'b0111, 0);
    step(1, 0, 4'b1111, 1);
    step(0, 0, 4'b0001, 0);
    step(0, 0, 4'b0000, 1);
    step(0, 0, 4'b0000, 0);
    // Randomized traffic with occasional squash and reset
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 24) == 0),
           rand_prefix(), ($urandom_range(0, 2) != 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
